// File: rtl/zcip_lane_array.sv
// ============================================================================
// Module   : zcip_lane_array
// Purpose  : Lockstep expansion of per-lane bit-column index masks into one
//            set-bit position per lane per step, LSB- or MSB-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zcip_lane_array #(
    parameter int LANES = 32,
    parameter int IDX_W = 7,
    parameter int OFF_W = $clog2(IDX_W),
    parameter int CNT_W = $clog2(IDX_W + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IDX_W-1:0] index_vector,
    input  logic                   msb_first,
    input  logic                   out_ready,
    output logic [LANES*OFF_W-1:0] shift_offset,
    output logic [LANES-1:0]       valid,
    output logic [LANES-1:0]       done,
    output logic                   all_done,
    output logic [CNT_W-1:0]       step_idx
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    logic [LANES*IDX_W-1:0]   r_rem;
    logic                     r_order;
    logic [CNT_W-1:0]         r_step;
    logic [LANES-1:0]         r_done;
    logic                     r_all_done;

    logic                     w_run;
    logic [LANES*IDX_W-1:0]   w_rem_next;
    logic [LANES-1:0]         w_load_zero;
    logic [LANES-1:0]         w_next_zero;

    assign w_run    = (r_state == ST_RUN);
    assign in_ready = (r_state == ST_IDLE);
    assign done     = r_done;
    assign all_done = r_all_done;
    assign step_idx = r_step;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [IDX_W-1:0] w_rem;
        logic [IDX_W-1:0] w_rem_clr;
        logic [OFF_W-1:0] w_pos;

        assign w_rem = r_rem[gi*IDX_W +: IDX_W];

        // Scan direction makes the last hit the wanted extreme bit.
        always_comb begin
            w_pos = '0;
            if (r_order) begin
                for (int j = 0; j < IDX_W; j++) begin
                    if (w_rem[j]) w_pos = OFF_W'(j);
                end
            end else begin
                for (int j = IDX_W - 1; j >= 0; j--) begin
                    if (w_rem[j]) w_pos = OFF_W'(j);
                end
            end
        end

        assign w_rem_clr                      = w_rem & ~(IDX_W'(1) << w_pos);
        assign w_rem_next[gi*IDX_W +: IDX_W]  = w_rem_clr;
        assign w_next_zero[gi]                = (w_rem_clr == '0);
        assign w_load_zero[gi]                = (index_vector[gi*IDX_W +: IDX_W] == '0);
        assign valid[gi]                      = w_run && (w_rem != '0);
        assign shift_offset[gi*OFF_W +: OFF_W] = w_run ? w_pos : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rem      <= '0;
            r_order    <= 1'b0;
            r_step     <= '0;
            r_done     <= '0;
            r_all_done <= 1'b0;
        end else begin
            r_all_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_rem   <= index_vector;
                        r_order <= msb_first;
                        r_step  <= '0;
                        r_done  <= w_load_zero;
                        // An empty group completes without ever entering RUN.
                        if (&w_load_zero) r_all_done <= 1'b1;
                        else              r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (out_ready) begin
                        r_rem  <= w_rem_next;
                        r_done <= r_done | w_next_zero;
                        if (&w_next_zero) begin
                            r_state    <= ST_IDLE;
                            r_all_done <= 1'b1;
                            r_step     <= '0;
                        end else begin
                            r_step <= r_step + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/zcip_lane_array.md
# zcip_lane_array

Parametrised, handshaked successor to the fixed 32-lane zero-column index processor array in BitWave. It accepts one group of `LANES` per-lane bit-column index masks (`IDX_W` bits each) and expands them in lockstep. Each step emits, per lane, the bit position of the next set bit. Emission order is selectable: LSB-first or MSB-first. Downstream back-pressure, per-lane done flags, a group-complete pulse and a step counter feed the shift/accumulate stage.

## Interface
- `LANES`, default 32: number of parallel lanes.
- `IDX_W`, default 7: index mask width per lane (≥2).
- `OFF_W`, default `$clog2(IDX_W)` (3): shift offset width per lane.
- `CNT_W`, default `$clog2(IDX_W+1)` (3): step counter width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  a group is offered on `index_vector`.
- `in_ready`  out  1  block accepts a group this cycle.
- `index_vector`  in  LANES*IDX_W  lane i mask at bits [i*IDX_W +: IDX_W].
- `msb_first`  in  1  order select, sampled only at load.
- `out_ready`  in  1  downstream consumes the current step.
- `shift_offset`  out  LANES*OFF_W  lane i offset at [i*OFF_W +: OFF_W].
- `valid`  out  LANES  lane i offset is meaningful this step.
- `done`  out  LANES  lane i mask exhausted (sticky until next load).
- `all_done`  out  1  one-cycle pulse: group fully expanded.
- `step_idx`  out  CNT_W  index of the step currently presented.

## Operation
- Two states: IDLE, RUN. Registers: `rem[i]` (IDX_W), `order_q`, `step_idx`, `done`, `all_done`, state.
- Reset: state=IDLE, `rem`=0, `order_q`=0, `step_idx`=0, `done`=0, `all_done`=0. Consequently `valid`=0, `shift_offset`=0, `in_ready`=1.
- `in_ready` = (state==IDLE).
- Load when `in_valid && in_ready`:
  - `rem[i]` ← mask i; `order_q` ← `msb_first`; `step_idx` ← 0.
  - `done[i]` ← (mask i == 0).
  - Next state is RUN. If all masks are zero, next state stays IDLE and `all_done` pulses.
- In RUN, lane outputs are combinational from registers only:
  - `valid[i]` = `rem[i]`≠0.
  - `shift_offset[i]` = position of the lowest set bit of `rem[i]` (`order_q`=0) or the highest set bit (`order_q`=1). It is 0 when `rem[i]`=0.
- Step advance when RUN and `out_ready`=1:
  - Each lane clears its presented bit.
  - `done[i]` ← 1 if `rem[i]` becomes 0.
  - `step_idx` increments.
  - If every lane's `rem` becomes 0: next state IDLE, `all_done` ← 1 for one cycle, `step_idx` ← 0.
- With `out_ready`=0 in RUN, all state and outputs hold.
- In IDLE: `valid`=0, `shift_offset`=0. `done` holds its last value.
- `in_valid` is ignored while RUN; no group is lost because `in_ready`=0.
- `out_ready` is ignored in IDLE.

## Timing
- Load at edge T → outputs for step 0 visible in cycle T+1.
- Group with max lane popcount P ≥ 1 and `out_ready` held high: last step is presented in cycle T+P, `all_done`=1 and `in_ready`=1 in cycle T+P+1. The next load can occur at edge T+P+1, so occupancy is P+1 cycles per group.
- All-zero group: `all_done`=1 in cycle T+1, `valid` never asserts, `in_ready` remains 1.
- `done[i]` rises the cycle after lane i's last bit is consumed. A lane loaded with zero mask has `done[i]`=1 from T+1.
- `step_idx` ranges 0..P-1, never exceeds IDX_W-1.
- Asserting `rst` mid-RUN immediately forces the reset values and abandons the group.

## Test plan
- Reset, then load (LANES=4, LSB-first) masks L0=0010110, L1=0000000, L2=1000001, L3=1111111 with `out_ready`=1:
  - L0 offsets 1,2,4.
  - L1 `valid`=0 throughout, `done`=1 from T+1.
  - L2 offsets 0,6.
  - L3 offsets 0..6.
  - `done[0]` rises at T+4; `all_done` pulses at T+8; `step_idx` runs 0..6.
- Same masks with `msb_first`=1 → L0 offsets 4,2,1; L2 offsets 6,0; L3 offsets 6..0.
- Back-pressure: drop `out_ready` for 3 cycles at step 2 → outputs and `step_idx`=2 frozen, then resume with no skipped or repeated offset.
- All-zero group → `all_done` at T+1, no `valid`. Then offer a second group at T+1 → accepted, back-to-back.
- `in_valid` with new masks during RUN → ignored, the current group completes unchanged. Then assert `rst` mid-group → all outputs return to reset values and `in_ready`=1.
